// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - opcode/funct3 encodings, FSM states and lane helpers for mem_access
package mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    // funct3[1:0] encodes access size for both loads and stores
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of a load word
module load_extend
    import mem_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  logic [2:0]        funct3_i,
    output logic [DWIDTH-1:0] data_o
);

    logic [DWIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_W:    data_o = shifted;
            F3_BU:   data_o = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
            F3_HU:   data_o = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store memory stage over a req/gnt/rvalid port
// MEM_MISALIGN_TRAP_EN: misaligned accesses error out instead of being force-aligned.
module mem_access
    import mem_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [DWIDTH-1:0] res_i,
    input  logic [DWIDTH-1:0] rs2_i,
    input  logic [4:0]        rd_i,
    input  logic [AWIDTH-1:0] pc_i,
    output logic              valid_o,
    output logic [DWIDTH-1:0] data_o,
    output logic [4:0]        rd_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    mem_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic [AWIDTH-1:0] pc_out_q, pc_out_d;

    logic              is_load, is_store, f3_legal, misalign_trap, in_req;
    logic [AWIDTH-1:0] addr_aligned;
    logic [DWIDTH-1:0] ext_data, store_wdata;

    load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
        .rdata_i  (mem_rdata_i),
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (ext_data)
    );

    always_comb begin
        is_load  = (opcode_i == OP_LOAD);
        is_store = (opcode_i == OP_STORE);
        f3_legal = is_load ? (funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                           : (funct3_i inside {F3_B, F3_H, F3_W});
        addr_aligned = res_i[AWIDTH-1:0];
        if (funct3_i[1:0] == 2'b01) begin
            addr_aligned[0] = 1'b0;
        end else if (funct3_i[1:0] == 2'b10) begin
            addr_aligned[1:0] = 2'b00;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_trap = access_misaligned(funct3_i, res_i[1:0]);
`else
        misalign_trap = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        data_d   = data_q;
        err_d    = err_q;
        rd_out_d = rd_out_q;
        pc_out_d = pc_out_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    we_d   = is_store;
                    f3_d   = funct3_i;
                    addr_d = addr_aligned;
                    rs2_d  = rs2_i;
                    rd_d   = rd_i;
                    pc_d   = pc_i;
                    if (!(is_load || is_store)) begin
                        state_d  = DONE;
                        data_d   = res_i;
                        err_d    = 1'b0;
                        rd_out_d = rd_i;
                        pc_out_d = pc_i;
                    end else if (!f3_legal || misalign_trap) begin
                        state_d  = DONE;
                        data_d   = '0;
                        err_d    = 1'b1;
                        rd_out_d = rd_i;
                        pc_out_d = pc_i;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (we_q) begin
                        state_d  = DONE;
                        data_d   = '0;
                        err_d    = 1'b0;
                        rd_out_d = rd_q;
                        pc_out_d = pc_q;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d  = DONE;
                    data_d   = ext_data;
                    err_d    = 1'b0;
                    rd_out_d = rd_q;
                    pc_out_d = pc_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            pc_q     <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            rd_out_q <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
            data_q   <= data_d;
            err_q    <= err_d;
            rd_out_q <= rd_out_d;
            pc_out_q <= pc_out_d;
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00:   store_wdata = {4{rs2_q[7:0]}};
            2'b01:   store_wdata = {2{rs2_q[15:0]}};
            default: store_wdata = rs2_q;
        endcase
    end

    // Port fields are only driven while a request is open so reset zeroes them at once
    assign in_req      = (state_q == REQ);
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req & we_q;
    assign mem_addr_o  = in_req ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
    assign mem_be_o    = in_req ? lane_be(f3_q, addr_q[1:0]) : 4'b0000;
    assign mem_wdata_o = in_req ? store_wdata : '0;

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign data_o  = data_q;
    assign err_o   = err_q;
    assign rd_o    = rd_out_q;
    assign pc_o    = pc_out_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - vector table, random model comparison and reset corner cases for mem_access
module tb_mem_access;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valid_i, ready_o, valid_o, err_o;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] res_i, rs2_i, pc_i, data_o, pc_o;
    logic [4:0]  rd_i, rd_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    always #5 clk = ~clk;

    mem_access #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .res_i(res_i), .rs2_i(rs2_i),
        .rd_i(rd_i), .pc_i(pc_i), .valid_o(valid_o), .data_o(data_o), .rd_o(rd_o),
        .pc_o(pc_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          gd;
        int          rv;
        exp_t        e;
    } vec_t;

    logic [31:0] mem [16];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prev_data;
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                                input logic [31:0] rs2, input logic [31:0] rdata, input int gd, input int rv,
                                input logic req, input logic [31:0] addr, input logic [3:0] be, input logic we,
                                input logic [31:0] wdata, input logic [31:0] data, input logic err, input int lat);
        vec_t v;
        v.op = op; v.f3 = f3; v.res = res; v.rs2 = rs2; v.rdata = rdata; v.gd = gd; v.rv = rv;
        v.e.req = req; v.e.addr = addr; v.e.be = be; v.e.we = we; v.e.wdata = wdata;
        v.e.data = data; v.e.err = err; v.e.lat = lat;
        return v;
    endfunction

    // Reference: access size in bytes, modular arithmetic for alignment, lanes and extension
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                                   input logic [31:0] rs2, input int gd, input int rv);
        exp_t        e;
        bit          ld, st, legal;
        int          size, off;
        longint      v, span;
        logic [31:0] a, w;
        e = '{req: 1'b0, addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0, data: 32'h0, err: 1'b0, lat: 1};
        ld = (op == LD);
        st = (op == ST);
        if (!ld && !st) begin
            e.data = res;
            return e;
        end
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) begin
            e.err = 1'b1;
            return e;
        end
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
`ifdef MEM_MISALIGN_TRAP_EN
        if (res % size != 0) begin
            e.err = 1'b1;
            return e;
        end
`endif
        a      = res - (res % size);
        off    = int'(a % 4);
        e.req  = 1'b1;
        e.addr = a - off;
        e.be   = 4'(((1 << size) - 1) << off);
        e.we   = st;
        if (st) begin
            e.wdata = (size == 1) ? rs2[7:0] * 32'h01010101 :
                      (size == 2) ? rs2[15:0] * 32'h00010001 : rs2;
            e.lat   = 2 + gd;
        end else begin
            w    = mem[a[5:2]] >> (8 * off);
            span = longint'(1) << (8 * size);
            v    = longint'(w) % span;
            if (f3[2] == 1'b0 && size < 4 && v >= span / 2) v = v - span;
            e.data = v[31:0];
            e.lat  = 3 + gd + rv;
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                          input logic [31:0] rs2, input int gd, input int rv, input exp_t e);
        logic [4:0]  rd, g_rd;
        logic [31:0] pc, g_pc, g_data, r_addr, r_wdata;
        logic [3:0]  r_be;
        logic        r_we, g_err;
        int          cyc, req_cnt, gnt_cyc;
        bit          granted, done, req_seen, hold_bad, busy_bad, stable_bad;
        rd = 5'($urandom);
        pc = $urandom & 32'hFFFF_FFFC;
        g_rd = 'x; g_pc = 'x; g_data = 'x; g_err = 1'bx;
        r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
        req_cnt = 0; gnt_cyc = 0;
        granted = 0; done = 0; req_seen = 0; hold_bad = 0; busy_bad = 0; stable_bad = 0;
        check({tag, " ready_idle"}, 32'(ready_o), 32'd1);
        valid_i = 1'b1; opcode_i = op; funct3_i = f3; res_i = res; rs2_i = rs2; rd_i = rd; pc_i = pc;
        @(posedge clk); #1;
        cyc = 1;
        while (!done && cyc < 60) begin
            valid_i = 1'b1; opcode_i = 7'($urandom); funct3_i = 3'($urandom);
            res_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom); pc_i = $urandom;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            if (valid_o) begin
                done = 1; valid_i = 1'b0;
                g_data = data_o; g_err = err_o; g_rd = rd_o; g_pc = pc_o;
                mem_rvalid_i = 1'($urandom_range(0, 1));
            end else begin
                if (ready_o) busy_bad = 1;
                if (data_o !== prev_data) hold_bad = 1;
                if (mem_req_o) begin
                    if (!req_seen) begin
                        r_addr = mem_addr_o; r_be = mem_be_o; r_we = mem_we_o; r_wdata = mem_wdata_o;
                    end else if (r_addr !== mem_addr_o || r_be !== mem_be_o || r_we !== mem_we_o ||
                                 r_wdata !== mem_wdata_o) begin
                        stable_bad = 1;
                    end
                    req_seen = 1;
                    if (req_cnt == gd) begin
                        mem_gnt_i = 1'b1; granted = 1; gnt_cyc = cyc;
                    end
                    req_cnt++;
                end
                if (granted && !r_we && cyc == gnt_cyc + 1 + rv) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem[r_addr[5:2]];
                end
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " req_issued"}, 32'(req_seen), 32'(e.req));
        if (e.req) begin
            check({tag, " mem_addr"}, r_addr, e.addr);
            check({tag, " mem_be"}, 32'(r_be), 32'(e.be));
            check({tag, " mem_we"}, 32'(r_we), 32'(e.we));
            if (e.we) check({tag, " mem_wdata"}, r_wdata, e.wdata);
        end
        check({tag, " data"}, g_data, e.data);
        check({tag, " err"}, 32'(g_err), 32'(e.err));
        check({tag, " rd"}, 32'(g_rd), 32'(rd));
        check({tag, " pc"}, g_pc, pc);
        check({tag, " latency"}, cyc, e.lat);
        check({tag, " busy_ready_low"}, 32'(busy_bad), 32'd0);
        check({tag, " output_hold"}, 32'(hold_bad), 32'd0);
        check({tag, " req_stable"}, 32'(stable_bad), 32'd0);
        @(posedge clk); #1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        check({tag, " one_cycle_valid"}, 32'(valid_o), 32'd0);
        check({tag, " back_to_idle"}, 32'(ready_o), 32'd1);
        prev_data = e.data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] res;
        int          kind, gd, rv;

        rst_ni = 1'b0; valid_i = 1'b0; opcode_i = '0; funct3_i = '0; res_i = '0; rs2_i = '0;
        rd_i = '0; pc_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        prev_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready_o", 32'(ready_o), 32'd1);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset mem_req_o", 32'(mem_req_o), 32'd0);
        check("reset data_o", data_o, 32'd0);
        check("reset err_o", 32'(err_o), 32'd0);
        check("reset rd_o", 32'(rd_o), 32'd0);
        check("reset pc_o", pc_o, 32'd0);
        check("reset mem_be_o", 32'(mem_be_o), 32'd0);
        check("reset mem_addr_o", mem_addr_o, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mk(ST, 3'd2, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 0, 0,
                          1, 32'h1000_0008, 4'hF, 1, 32'hDEAD_BEEF, 32'h0, 0, 2));
        vecs.push_back(mk(ST, 3'd0, 32'h1000_0003, 32'h0000_00A5, 32'h0, 0, 0,
                          1, 32'h1000_0000, 4'h8, 1, 32'hA5A5_A5A5, 32'h0, 0, 2));
        vecs.push_back(mk(LD, 3'd0, 32'h1000_0001, 32'h0, 32'h0000_8000, 0, 0,
                          1, 32'h1000_0000, 4'h2, 0, 32'h0, 32'hFFFF_FF80, 0, 3));
        vecs.push_back(mk(LD, 3'd4, 32'h1000_0001, 32'h0, 32'h0000_8000, 0, 0,
                          1, 32'h1000_0000, 4'h2, 0, 32'h0, 32'h0000_0080, 0, 3));
        vecs.push_back(mk(LD, 3'd1, 32'h1000_0002, 32'h0, 32'h8001_0000, 0, 0,
                          1, 32'h1000_0000, 4'hC, 0, 32'h0, 32'hFFFF_8001, 0, 3));
        vecs.push_back(mk(ALU, 3'd0, 32'h1234_5678, 32'h1, 32'h0, 0, 0,
                          0, 32'h0, 4'h0, 0, 32'h0, 32'h1234_5678, 0, 1));
`ifdef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk(LD, 3'd2, 32'h1000_0002, 32'h0, 32'hCAFE_F00D, 0, 0,
                          0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(LD, 3'd1, 32'h1000_0005, 32'h0, 32'h00C0_FFEE, 0, 0,
                          0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 1));
`else
        vecs.push_back(mk(LD, 3'd2, 32'h1000_0002, 32'h0, 32'hCAFE_F00D, 0, 0,
                          1, 32'h1000_0000, 4'hF, 0, 32'h0, 32'hCAFE_F00D, 0, 3));
        vecs.push_back(mk(LD, 3'd1, 32'h1000_0005, 32'h0, 32'h00C0_FFEE, 0, 0,
                          1, 32'h1000_0004, 4'h3, 0, 32'h0, 32'hFFFF_FFEE, 0, 3));
`endif
        vecs.push_back(mk(LD, 3'd3, 32'h1000_0000, 32'h0, 32'h0, 0, 0,
                          0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(ST, 3'd4, 32'h1000_0000, 32'h5555_5555, 32'h0, 0, 0,
                          0, 32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(ST, 3'd1, 32'h1000_0006, 32'h1234_ABCD, 32'h0, 2, 0,
                          1, 32'h1000_0004, 4'hC, 1, 32'hABCD_ABCD, 32'h0, 0, 4));
        vecs.push_back(mk(LD, 3'd5, 32'h1000_0004, 32'h0, 32'h1234_F00F, 1, 2,
                          1, 32'h1000_0004, 4'h3, 0, 32'h0, 32'h0000_F00F, 0, 6));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].op == LD) mem[vecs[i].res[5:2]] = vecs[i].rdata;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].f3, vecs[i].res, vecs[i].rs2,
                   vecs[i].gd, vecs[i].rv, vecs[i].e);
        end

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 4);
            op   = (kind < 2) ? LD : (kind < 4) ? ST : ((kind == 4 && n[0]) ? 7'b0010011 : ALU);
            f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (op == LD && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
            res  = (op == LD || op == ST) ? 32'h1000_0000 + 32'($urandom_range(0, 63)) : $urandom;
            gd   = $urandom_range(0, 2);
            rv   = $urandom_range(0, 2);
            e    = model(op, f3, res, $urandom, gd, rv);
            rs2_i = '0;
            begin
                logic [31:0] rs2;
                rs2 = $urandom;
                e   = model(op, f3, res, rs2, gd, rv);
                run_op($sformatf("rnd%0d", n), op, f3, res, rs2, gd, rv, e);
            end
        end

        // Reset while a request is open must drop it without waiting for a clock
        valid_i = 1'b1; opcode_i = LD; funct3_i = 3'd2; res_i = 32'h1000_0000; rs2_i = '0;
        rd_i = 5'd7; pc_i = 32'h100;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("rst_in_req req_before", 32'(mem_req_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_in_req req_dropped", 32'(mem_req_o), 32'd0);
        check("rst_in_req ready", 32'(ready_o), 32'd1);
        check("rst_in_req data_cleared", data_o, 32'd0);
        check("rst_in_req valid", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        prev_data = '0;
        @(posedge clk); #1;

        valid_i = 1'b1; opcode_i = LD; funct3_i = 3'd2; res_i = 32'h1000_0004;
        @(posedge clk); #1;
        valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        check("rst_in_wait busy", 32'(ready_o), 32'd0);
        check("rst_in_wait no_req", 32'(mem_req_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_in_wait ready", 32'(ready_o), 32'd1);
        check("rst_in_wait req", 32'(mem_req_o), 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_in_wait late_rvalid_ignored%0d", k), 32'(valid_o), 32'd0);
            check($sformatf("rst_in_wait data_zero%0d", k), data_o, 32'd0);
            @(posedge clk); #1;
        end

        e = model(ALU, 3'd0, 32'h0BAD_F00D, 32'h0, 0, 0);
        run_op("after_reset", ALU, 3'd0, 32'h0BAD_F00D, 32'h0, 0, 0, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of the execute ALU.
- Consumes the ALU result (effective address or passthrough value), rs2 store data, funct3 and opcode.
- Performs loads and stores over a req/gnt/rvalid data-memory port, with byte-lane steering and sign/zero extension.
- Hands a single-cycle valid result to writeback. Stalls upstream via ready_o while an access is outstanding.

Parameters:
- DWIDTH, 32, data width; only 32 is supported.
- AWIDTH, 32, address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous and active-low
- valid_i  in  1  execute result valid
- ready_o  out  1  stage can accept; high only in IDLE
- opcode_i  in  7  instruction opcode
- funct3_i  in  3  access size / signedness
- res_i  in  DWIDTH  ALU result; address for load/store
- rs2_i  in  DWIDTH  store data
- rd_i  in  5  destination register
- pc_i  in  AWIDTH  instruction PC
- valid_o  out  1  one-cycle result strobe
- data_o  out  DWIDTH  load data or passthrough res_i
- rd_o  out  5  captured rd
- pc_o  out  AWIDTH  captured pc
- err_o  out  1  access error, qualified by valid_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  AWIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  DWIDTH  lane-replicated store data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  load data valid
- mem_rdata_i  in  DWIDTH  load data

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - All outputs are 0 except ready_o=1.
  - mem_req_o drops immediately. A later mem_rvalid_i is ignored.
- Capture: on valid_i && ready_o, register opcode, funct3, res, rs2, rd and pc. Inputs are ignored when ready_o=0.
- Opcodes:
  - LOAD = 7'b0000011.
  - STORE = 7'b0100011.
  - Anything else is passthrough.
- FSM: IDLE, REQ, WAIT, DONE.
  - IDLE → DONE: on capture of a passthrough, an illegal funct3, or (with the macro) a misaligned access. No memory activity.
  - IDLE → REQ: on capture of a legal load/store.
  - REQ: mem_req_o=1 with addr/we/be/wdata held stable until mem_gnt_i. On gnt, a store goes to DONE and a load goes to WAIT.
  - WAIT: on mem_rvalid_i, register the extended data, then go to DONE.
  - DONE: valid_o=1 for exactly one cycle, then return to IDLE.
- mem_rvalid_i is ignored in any state other than WAIT. Memory never asserts rvalid in the gnt cycle.
- Latency from the capture edge:
  - Passthrough: valid_o one cycle later.
  - Store with gnt in the first REQ cycle: 2 cycles.
  - Load: rvalid cycle + 1.
- Legal funct3:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other funct3 → err_o=1, data_o=0.
- Store lanes (a = addr[1:0]):
  - SB: be = 4'b0001<<a, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<a, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Load lanes:
  - Shift mem_rdata_i right by 8*a.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Loads drive be with the same pattern as stores.
- Passthrough: data_o = res_i, err_o = 0.
- Stores: data_o = 0.
- data_o, rd_o, pc_o and err_o hold their values until the next DONE.
- Misaligned access: a halfword with addr[0]=1, or a word with addr[1:0]≠0. Handling is set by the optional feature.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no request and goes IDLE → DONE with err_o=1, data_o=0.
- Undefined: offending low address bits are cleared (halfword: addr[0]; word: addr[1:0]), the access proceeds aligned, and err_o=0.

Decomposition:
- Shared package mem_pkg:
  - OP_LOAD and OP_STORE opcode constants.
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum mem_state_e {IDLE, REQ, WAIT, DONE}.
- One combinational sub-module, load_extend (inputs: rdata, offset, funct3; output: extended data), instantiated once.

Test Plan:
- SW addr 0x1000_0008, rs2 0xDEAD_BEEF, gnt on first REQ cycle → mem_addr_o=0x1000_0008, be=4'b1111, we=1; valid_o two cycles after capture; ready_o low for those cycles.
- SB addr 0x1000_0003, rs2 0x0000_00A5 → be=4'b1000, wdata=0xA5A5_A5A5.
- LB addr 0x1000_0001 with rdata 0x0000_8000 → data_o=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- LH addr 0x1000_0002 with rdata 0x8001_0000 → data_o=0xFFFF_8001.
- Passthrough opcode 7'b0110011, res 0x1234_5678 → valid_o one cycle later, data_o=0x1234_5678, no mem_req_o.
- LW addr 0x1000_0002:
  - With MEM_MISALIGN_TRAP_EN: err_o=1 and no request.
  - Without it: mem_addr_o=0x1000_0000.
  - Separately: assert rst_ni=0 in WAIT → mem_req_o=0 and ready_o=1 immediately; a following rvalid produces no valid_o.
